forwarding_scoreboard: RTL and testbench
========================================

Name: forwarding_scoreboard

Overview:
- Parametrised successor to the fixed two-source EX forwarding/load-use logic.
- Tracks in-flight register writers in a DEPTH-slot shift pipe downstream of EX (slot 0 = EX_MEM, slot 1 = MEM_WB, ...).
- Each producer carries its own availability slot, so ALU, load and multi-cycle results share one scheme.
- Sits beside the ID_EX barrier. Drives the EX operand-forwarding mux selects and a hazard stall / bubble request to the pipeline controller.

Parameters:
- NUM_REGS, 8, architectural register count; REG_W = $clog2(NUM_REGS).
- DEPTH, 3, number of tracked producer slots downstream of EX; min 1, max 7.
- SEL_W, $clog2(DEPTH+1), width of a forwarding select (0 = regfile pass, k = slot k-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pipe_advance  in  1  downstream barriers load this cycle (no memory stall)
- flush  in  1  squash the instruction currently in ID_EX
- cons_valid  in  1  ID_EX holds a real instruction
- cons_sr1 / cons_sr2  in  REG_W each  source registers
- cons_sr1_req / cons_sr2_req  in  1 each  source actually read
- cons_wr  in  1  instruction writes regfile
- cons_dest  in  REG_W  destination register
- cons_avail  in  SEL_W  first slot index at which its result is forwardable (ALU 0, load 1)
- fwd_a_sel / fwd_b_sel  out  SEL_W  EX operand A/B mux select
- hazard_stall  out  1  hold IF, IF_ID, ID_EX; insert bubble into slot 0
- slot_valid  out  DEPTH  per-slot occupancy (debug)

Behaviour:
- Slot state per entry: valid, dest[REG_W], avail[SEL_W].
- Reset (rst_n=0 at clk edge): all valid cleared. Outputs then read slot_valid=0, fwd sels=0, hazard_stall=0.
- Match, per source (combinational): slot i matches when slot valid, sr_req=1 and dest==sr.
  - Lowest index (youngest) match wins.
  - No match gives sel 0. Regfile is write-before-read, so retired values need no forwarding.
- Ready: a winning slot i is ready when i >= avail. Not ready raises the stall for that operand.
- hazard_stall = cons_valid & ~flush & (A not ready | B not ready).
- Forwarding select = i+1 even when stalling. Selects are don't-care while hazard_stall=1; bench does not check them then.
- Shift on a clk edge with pipe_advance=1:
  - slot[i+1] <= slot[i]; slot[DEPTH-1] retires.
  - slot 0 <= {cons_valid & cons_wr & ~flush & ~hazard_stall, cons_dest, cons_avail}. Otherwise slot 0 is a bubble (valid=0).
- pipe_advance=0: all slots hold. Outputs are recomputed from held state. A stall persists without aging.
- A load-use stall resolves after exactly one advancing cycle (producer moves from slot 0 to slot 1).
- cons_avail >= DEPTH: stalls until the producer retires, then reads the regfile (sel 0).
- Simultaneous flush and hazard: flush wins, no stall, bubble inserted.
- Reset mid-stall: stall drops the cycle after reset; all producers are forgotten.

Optional Feature:
- Macro FORWARDING_SCOREBOARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_fwd_count[31:0].
  - perf_stall_cycles increments on each clk with hazard_stall=1 & pipe_advance=1.
  - perf_fwd_count increments on each advancing, non-stalled cycle with a nonzero select on either operand (+1 per operand).
  - Both counters saturate at all-ones and clear on reset.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- lc3b_types gets a SEL encoding constant for "regfile pass" (0) and a packed typedef lc3b_fwd_slot {valid, dest, avail}.
- The existing lc3b_reg typedef is reused for register fields.
- One sub-module, fwd_slot_match: combinational priority finder. Takes the slot array plus one source and returns hit, index and ready. It is instantiated twice (A, B).

Test Plan:
- Reset: hold rst_n=0 two cycles with garbage inputs -> slot_valid=0, fwd_a_sel=0, fwd_b_sel=0, hazard_stall=0.
- ALU chain: ADD dest R1 avail 0 advances; next consumer sr1=R1 req -> fwd_a_sel=1, hazard_stall=0. One more advance with an unrelated consumer -> fwd_a_sel=2.
- Load-use: LDR dest R2 avail 1 in slot 0; consumer sr2=R2 -> hazard_stall=1 for one advancing cycle, slot 0 bubble. Next cycle fwd_b_sel=2, stall=0.
- Youngest wins: slot0 dest R3 avail 0, slot1 dest R3 avail 0; consumer sr1=sr2=R3 -> fwd_a_sel=fwd_b_sel=1.
- Memory stall: load-use hazard with pipe_advance=0 for 3 cycles -> stall held, slots unchanged. Then advance -> resolves as in the load-use case.
- Flush: consumer cons_wr=1 dest R4 with flush=1 and a pending hazard -> hazard_stall=0. After advance slot_valid[0]=0, and a later consumer reading R4 gets sel 0.

Source files
------------

// File: rtl/forwarding_scoreboard_pkg.sv
// Shared types for the EX forwarding scoreboard.
// Optional perf counters: FORWARDING_SCOREBOARD_PERF_EN.
package forwarding_scoreboard_pkg;

  localparam int unsigned SEL_REGFILE = 0;

  typedef logic [2:0] lc3b_reg;

  typedef struct packed {
    logic       valid;
    lc3b_reg    dest;
    logic [1:0] avail;
  } lc3b_fwd_slot;

  function automatic int unsigned sel_w(
    input int unsigned depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/forwarding_scoreboard_match.sv
// Priority finder: youngest slot writing a source register,
// plus whether its result has reached its forwardable slot.
module fwd_slot_match
  import forwarding_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned REG_W = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0][REG_W-1:0] dest_i,
  input  logic [DEPTH-1:0][SEL_W-1:0] avail_i,
  input  logic [REG_W-1:0]            sr_i,
  input  logic                        sr_req_i,
  output logic                        hit_o,
  output logic [SEL_W-1:0]            idx_o,
  output logic                        ready_o
);

  // Scan oldest to youngest so the youngest match lands last.
  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    ready_o = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_i[i] && sr_req_i && (dest_i[i] == sr_i)) begin
        hit_o   = 1'b1;
        idx_o   = SEL_W'(i);
        ready_o = (SEL_W'(i) >= avail_i[i]);
      end
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// EX forwarding selects and load-use stall from a shift pipe
// of in-flight writers. Perf: FORWARDING_SCOREBOARD_PERF_EN.
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 8,
  parameter  int unsigned DEPTH    = 3,
  localparam int unsigned REG_W    = $clog2(NUM_REGS),
  localparam int unsigned SEL_W    = sel_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_advance,
  input  logic             flush,
  input  logic             cons_valid,
  input  logic [REG_W-1:0] cons_sr1,
  input  logic [REG_W-1:0] cons_sr2,
  input  logic             cons_sr1_req,
  input  logic             cons_sr2_req,
  input  logic             cons_wr,
  input  logic [REG_W-1:0] cons_dest,
  input  logic [SEL_W-1:0] cons_avail,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic             hazard_stall,
  output logic [DEPTH-1:0] slot_valid
`ifdef FORWARDING_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_fwd_count
`endif
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic [SEL_W-1:0] avail;
  } slot_t;

  slot_t [DEPTH-1:0] slot_q;
  slot_t [DEPTH-1:0] slot_d;

  logic [DEPTH-1:0]            sv;
  logic [DEPTH-1:0][REG_W-1:0] sd;
  logic [DEPTH-1:0][SEL_W-1:0] sa;

  logic             hit_a;
  logic             hit_b;
  logic             rdy_a;
  logic             rdy_b;
  logic [SEL_W-1:0] idx_a;
  logic [SEL_W-1:0] idx_b;
  logic             push;

  always_comb begin
    sv = '0;
    sd = '0;
    sa = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sv[i] = slot_q[i].valid;
      sd[i] = slot_q[i].dest;
      sa[i] = slot_q[i].avail;
    end
  end

  fwd_slot_match #(
    .DEPTH (DEPTH),
    .REG_W (REG_W),
    .SEL_W (SEL_W)
  ) u_match_a (
    .valid_i  (sv),
    .dest_i   (sd),
    .avail_i  (sa),
    .sr_i     (cons_sr1),
    .sr_req_i (cons_sr1_req),
    .hit_o    (hit_a),
    .idx_o    (idx_a),
    .ready_o  (rdy_a)
  );

  fwd_slot_match #(
    .DEPTH (DEPTH),
    .REG_W (REG_W),
    .SEL_W (SEL_W)
  ) u_match_b (
    .valid_i  (sv),
    .dest_i   (sd),
    .avail_i  (sa),
    .sr_i     (cons_sr2),
    .sr_req_i (cons_sr2_req),
    .hit_o    (hit_b),
    .idx_o    (idx_b),
    .ready_o  (rdy_b)
  );

  assign fwd_a_sel = hit_a ? idx_a + SEL_W'(1)
                           : SEL_W'(SEL_REGFILE);
  assign fwd_b_sel = hit_b ? idx_b + SEL_W'(1)
                           : SEL_W'(SEL_REGFILE);

  assign hazard_stall = cons_valid & ~flush
                      & (~rdy_a | ~rdy_b);
  assign slot_valid   = sv;

  // Stalled or flushed consumers enter as a bubble.
  assign push = cons_valid & cons_wr
              & ~flush & ~hazard_stall;

  always_comb begin
    slot_d = slot_q;
    if (pipe_advance) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        slot_d[i] = slot_q[i-1];
      end
      slot_d[0].valid = push;
      slot_d[0].dest  = cons_dest;
      slot_d[0].avail = cons_avail;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

`ifdef FORWARDING_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fwd_cnt_q;
  logic [1:0]  fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_inc = {1'b0, |fwd_a_sel} + {1'b0, |fwd_b_sel};
    fwd_sum = {1'b0, fwd_cnt_q} + {31'b0, fwd_inc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (pipe_advance) begin
      if (hazard_stall) begin
        if (~&stall_cnt_q) begin
          stall_cnt_q <= stall_cnt_q + 32'd1;
        end
      end else begin
        fwd_cnt_q <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_fwd_count    = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Randomised and directed checks of forwarding_scoreboard
// against a producer-age model.
module tb_forwarding_scoreboard;

  localparam int D  = 3;
  localparam int RW = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pipe_advance = 1'b0;
  logic          flush = 1'b0;
  logic          cons_valid = 1'b0;
  logic [RW-1:0] cons_sr1 = '0;
  logic [RW-1:0] cons_sr2 = '0;
  logic          cons_sr1_req = 1'b0;
  logic          cons_sr2_req = 1'b0;
  logic          cons_wr = 1'b0;
  logic [RW-1:0] cons_dest = '0;
  logic [SW-1:0] cons_avail = '0;
  logic [SW-1:0] fwd_a_sel;
  logic [SW-1:0] fwd_b_sel;
  logic          hazard_stall;
  logic [D-1:0]  slot_valid;
`ifdef FORWARDING_SCOREBOARD_PERF_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_fwd_count;
`endif

  forwarding_scoreboard #(
    .NUM_REGS (8),
    .DEPTH    (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_advance (pipe_advance),
    .flush        (flush),
    .cons_valid   (cons_valid),
    .cons_sr1     (cons_sr1),
    .cons_sr2     (cons_sr2),
    .cons_sr1_req (cons_sr1_req),
    .cons_sr2_req (cons_sr2_req),
    .cons_wr      (cons_wr),
    .cons_dest    (cons_dest),
    .cons_avail   (cons_avail),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .hazard_stall (hazard_stall),
    .slot_valid   (slot_valid)
`ifdef FORWARDING_SCOREBOARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_fwd_count    (perf_fwd_count)
`endif
  );

  always #5 clk = ~clk;

  // Each in-flight writer remembers how many advances it has seen.
  typedef struct {
    int dest;
    int avail;
    int age;
  } prod_t;

  prod_t mq[$];
  int    checks = 0;
  int    errors = 0;
  bit    known  = 1'b0;
  bit    exp_h  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void lookup(input int sr, input bit req,
                                 output int sel, output bit nr);
    int best;
    best = -1;
    sel  = 0;
    nr   = 1'b0;
    if (req) begin
      foreach (mq[k]) begin
        if (mq[k].dest == sr &&
            (best < 0 || mq[k].age < mq[best].age)) best = k;
      end
    end
    if (best >= 0) begin
      sel = mq[best].age + 1;
      nr  = mq[best].age < mq[best].avail;
    end
  endfunction

  task automatic drive(input bit v, input int s1, input bit q1,
                       input int s2, input bit q2, input bit w,
                       input int dst, input int av,
                       input bit adv, input bit fl);
    int ea, eb;
    bit na, nb;
    logic [D-1:0] sv;
    cons_valid   = v;
    cons_sr1     = RW'(s1);
    cons_sr1_req = q1;
    cons_sr2     = RW'(s2);
    cons_sr2_req = q2;
    cons_wr      = w;
    cons_dest    = RW'(dst);
    cons_avail   = SW'(av);
    pipe_advance = adv;
    flush        = fl;
    @(negedge clk);
    if (known) begin
      lookup(s1, q1, ea, na);
      lookup(s2, q2, eb, nb);
      exp_h = v & ~fl & (na | nb);
      sv = '0;
      foreach (mq[k]) sv[mq[k].age] = 1'b1;
      chk("slot_valid", 32'(slot_valid), 32'(sv));
      chk("stall", 32'(hazard_stall), 32'(exp_h));
      if (!exp_h) begin
        chk("sel_a", 32'(fwd_a_sel), ea);
        chk("sel_b", 32'(fwd_b_sel), eb);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      known = 1'b1;
    end else if (pipe_advance) begin
      foreach (mq[k]) mq[k].age++;
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (mq[k].age >= D) mq.delete(k);
      end
      if (cons_valid && cons_wr && !flush && !exp_h)
        mq.push_front('{int'(cons_dest), int'(cons_avail), 0});
    end
    #1;
  endtask

  initial begin
    // Reset with garbage inputs
    rst_n = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    tick();
    drive(1, 2, 1, 3, 1, 1, 5, 0, 1, 0);
    chk("rst_slots", 32'(slot_valid), 0);
    chk("rst_sel_a", 32'(fwd_a_sel), 0);
    chk("rst_sel_b", 32'(fwd_b_sel), 0);
    chk("rst_stall", 32'(hazard_stall), 0);
    tick();
    rst_n = 1'b1;

    // ALU chain
    drive(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("alu_sel1", 32'(fwd_a_sel), 1);
    chk("alu_stall", 32'(hazard_stall), 0);
    tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("alu_sel2", 32'(fwd_a_sel), 2);
    tick();

    // Load-use
    drive(1, 0, 0, 0, 0, 1, 2, 1, 1, 0);
    tick();
    drive(1, 0, 0, 2, 1, 1, 5, 0, 1, 0);
    chk("ldu_stall", 32'(hazard_stall), 1);
    tick();
    drive(1, 0, 0, 2, 1, 1, 5, 0, 1, 0);
    chk("ldu_bubble", 32'(slot_valid[0]), 0);
    chk("ldu_stall2", 32'(hazard_stall), 0);
    chk("ldu_sel_b", 32'(fwd_b_sel), 2);
    tick();

    // Youngest wins
    drive(1, 0, 0, 0, 0, 1, 3, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 1, 0);
    tick();
    drive(1, 3, 1, 3, 1, 0, 0, 0, 1, 0);
    chk("young_a", 32'(fwd_a_sel), 1);
    chk("young_b", 32'(fwd_b_sel), 1);
    tick();

    // Memory stall holds the hazard without aging
    drive(1, 0, 0, 0, 0, 1, 6, 1, 1, 0);
    tick();
    for (int n = 0; n < 3; n++) begin
      drive(1, 6, 1, 0, 0, 1, 0, 0, 0, 0);
      chk("mem_hold", 32'(hazard_stall), 1);
      tick();
    end
    drive(1, 6, 1, 0, 0, 1, 0, 0, 1, 0);
    chk("mem_adv", 32'(hazard_stall), 1);
    tick();
    drive(1, 6, 1, 0, 0, 1, 0, 0, 1, 0);
    chk("mem_res", 32'(hazard_stall), 0);
    chk("mem_sel", 32'(fwd_a_sel), 2);
    tick();

    // Flush beats hazard
    drive(1, 0, 0, 0, 0, 1, 7, 1, 1, 0);
    tick();
    drive(1, 7, 1, 0, 0, 1, 4, 0, 1, 1);
    chk("fl_stall", 32'(hazard_stall), 0);
    tick();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("fl_slot0", 32'(slot_valid[0]), 0);
    chk("fl_sel", 32'(fwd_a_sel), 0);
    tick();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 7) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
